// File: rtl/slot_pkg.sv
// Shared definitions for SlotArr users: slot status codes, sequencer states
// and default field widths.
package slot_pkg;

  localparam int unsigned INDEX_WIDTH_DEF    = 3;
  localparam int unsigned SRC_ADDR_WIDTH_DEF = 32;
  localparam int unsigned SRC_SIZE_WIDTH_DEF = 26;
  localparam int unsigned DST_ADDR_WIDTH_DEF = 32;
  localparam int unsigned DST_SIZE_WIDTH_DEF = 26;
  localparam int unsigned STATUS_WIDTH_DEF   = 2;
  localparam int unsigned PROFILE_WIDTH_DEF  = 32;

  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'd0,
    SLOT_READY = 2'd1,
    SLOT_DONE  = 2'd2,
    SLOT_ERROR = 2'd3
  } slot_status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_WB,
    S_NEXT,
    S_FIN
  } seq_state_e;

endpackage

// File: rtl/slot_sequencer.sv
// Walks a slot range in SlotArr, issues one DMA command per READY slot and
// writes back completion status plus a cycle-count profile.
module slot_sequencer
  import slot_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH    = INDEX_WIDTH_DEF,
  parameter int unsigned SRC_ADDR_WIDTH = SRC_ADDR_WIDTH_DEF,
  parameter int unsigned SRC_SIZE_WIDTH = SRC_SIZE_WIDTH_DEF,
  parameter int unsigned DST_ADDR_WIDTH = DST_ADDR_WIDTH_DEF,
  parameter int unsigned DST_SIZE_WIDTH = DST_SIZE_WIDTH_DEF,
  parameter int unsigned STATUS_WIDTH   = STATUS_WIDTH_DEF,
  parameter int unsigned PROFILE_WIDTH  = PROFILE_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [INDEX_WIDTH-1:0]    first_idx,
  input  logic [INDEX_WIDTH-1:0]    last_idx,
  input  logic                      abort,
  output logic                      busy,
  output logic                      seq_done,
  output logic                      seq_err,
  output logic [INDEX_WIDTH-1:0]    rd_index,
  input  logic [SRC_ADDR_WIDTH-1:0] rd_src_addr,
  input  logic [SRC_SIZE_WIDTH-1:0] rd_src_size,
  input  logic [DST_ADDR_WIDTH-1:0] rd_des_addr,
  input  logic [DST_SIZE_WIDTH-1:0] rd_des_size,
  input  logic [STATUS_WIDTH-1:0]   rd_status,
  output logic [INDEX_WIDTH-1:0]    wr_index,
  output logic [STATUS_WIDTH-1:0]   wr_status,
  output logic                      set_status,
  output logic [PROFILE_WIDTH-1:0]  wr_profile,
  output logic                      set_profile,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [SRC_ADDR_WIDTH-1:0] cmd_src_addr,
  output logic [SRC_SIZE_WIDTH-1:0] cmd_src_size,
  output logic [DST_ADDR_WIDTH-1:0] cmd_des_addr,
  output logic [DST_SIZE_WIDTH-1:0] cmd_des_size,
  input  logic                      dma_done,
  input  logic                      dma_err
);

  seq_state_e                state_q;
  logic [INDEX_WIDTH-1:0]    cur_q, last_q, cur_d;
  logic                      abort_pend_q;
  logic                      failed_q;
  logic [PROFILE_WIDTH-1:0]  prof_q, prof_d;

  logic                      seq_done_q, seq_err_q;
  logic [INDEX_WIDTH-1:0]    rd_index_q, wr_index_q;
  logic [STATUS_WIDTH-1:0]   wr_status_q;
  logic                      set_status_q, set_profile_q;
  logic [PROFILE_WIDTH-1:0]  wr_profile_q;
  logic                      cmd_valid_q;
  logic [SRC_ADDR_WIDTH-1:0] cmd_src_addr_q;
  logic [SRC_SIZE_WIDTH-1:0] cmd_src_size_q;
  logic [DST_ADDR_WIDTH-1:0] cmd_des_addr_q;
  logic [DST_SIZE_WIDTH-1:0] cmd_des_size_q;

  // Index wraps naturally modulo 2**INDEX_WIDTH; profile counter saturates.
  always_comb begin
    cur_d  = cur_q + INDEX_WIDTH'(1);
    prof_d = (&prof_q) ? prof_q : prof_q + PROFILE_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cur_q          <= '0;
      last_q         <= '0;
      abort_pend_q   <= 1'b0;
      failed_q       <= 1'b0;
      prof_q         <= '0;
      seq_done_q     <= 1'b0;
      seq_err_q      <= 1'b0;
      rd_index_q     <= '0;
      wr_index_q     <= '0;
      wr_status_q    <= '0;
      set_status_q   <= 1'b0;
      wr_profile_q   <= '0;
      set_profile_q  <= 1'b0;
      cmd_valid_q    <= 1'b0;
      cmd_src_addr_q <= '0;
      cmd_src_size_q <= '0;
      cmd_des_addr_q <= '0;
      cmd_des_size_q <= '0;
    end else begin
      seq_done_q    <= 1'b0;
      set_status_q  <= 1'b0;
      set_profile_q <= 1'b0;
      if (state_q != S_IDLE && abort) abort_pend_q <= 1'b1;

      unique case (state_q)
        S_IDLE: begin
          abort_pend_q <= 1'b0;
          if (start) begin
            cur_q      <= first_idx;
            last_q     <= last_idx;
            rd_index_q <= first_idx;
            seq_err_q  <= 1'b0;
            state_q    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (rd_status == STATUS_WIDTH'(SLOT_READY)) begin
            cmd_src_addr_q <= rd_src_addr;
            cmd_src_size_q <= rd_src_size;
            cmd_des_addr_q <= rd_des_addr;
            cmd_des_size_q <= rd_des_size;
            cmd_valid_q    <= 1'b1;
            state_q        <= S_ISSUE;
          end else begin
            state_q <= S_NEXT;
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            prof_q      <= '0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          prof_q <= prof_d;
          // The completing cycle is counted too, so the written profile is prof_d.
          if (dma_err || dma_done) begin
            wr_index_q    <= cur_q;
            wr_status_q   <= dma_err ? STATUS_WIDTH'(SLOT_ERROR) : STATUS_WIDTH'(SLOT_DONE);
            wr_profile_q  <= prof_d;
            set_status_q  <= 1'b1;
            set_profile_q <= 1'b1;
            failed_q      <= dma_err;
            state_q       <= S_WB;
          end
        end
        S_WB: begin
          if (failed_q) begin
            seq_err_q  <= 1'b1;
            seq_done_q <= 1'b1;
            state_q    <= S_FIN;
          end else begin
            state_q <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (cur_q == last_q || abort_pend_q) begin
            seq_done_q <= 1'b1;
            state_q    <= S_FIN;
          end else begin
            cur_q      <= cur_d;
            rd_index_q <= cur_d;
            state_q    <= S_FETCH;
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign seq_done     = seq_done_q;
  assign seq_err      = seq_err_q;
  assign rd_index     = rd_index_q;
  assign wr_index     = wr_index_q;
  assign wr_status    = wr_status_q;
  assign set_status   = set_status_q;
  assign wr_profile   = wr_profile_q;
  assign set_profile  = set_profile_q;
  assign cmd_valid    = cmd_valid_q;
  assign cmd_src_addr = cmd_src_addr_q;
  assign cmd_src_size = cmd_src_size_q;
  assign cmd_des_addr = cmd_des_addr_q;
  assign cmd_des_size = cmd_des_size_q;

endmodule

// File: tb/tb_slot_sequencer.sv
// Self-checking bench for slot_sequencer: SlotArr and DMA engine are modelled
// here; expected commands and final slot states come from a range-walk model.
module tb_slot_sequencer;
  import slot_pkg::*;

  localparam int IW  = 3;
  localparam int SAW = 32;
  localparam int SSW = 26;
  localparam int DAW = 32;
  localparam int DSW = 26;
  localparam int SW  = 2;
  localparam int PW  = 32;
  localparam int NS  = 8;

  logic           clk, reset, start, abort, cmd_ready, dma_done, dma_err;
  logic [IW-1:0]  first_idx, last_idx;
  logic           busy, seq_done, seq_err, set_status, set_profile, cmd_valid;
  logic [IW-1:0]  rd_index, wr_index;
  logic [SAW-1:0] rd_src_addr, cmd_src_addr;
  logic [SSW-1:0] rd_src_size, cmd_src_size;
  logic [DAW-1:0] rd_des_addr, cmd_des_addr;
  logic [DSW-1:0] rd_des_size, cmd_des_size;
  logic [SW-1:0]  rd_status, wr_status;
  logic [PW-1:0]  wr_profile;

  logic [SAW-1:0] m_sa [NS];
  logic [SSW-1:0] m_ss [NS];
  logic [DAW-1:0] m_da [NS];
  logic [DSW-1:0] m_ds [NS];
  logic [SW-1:0]  m_st [NS];
  logic [PW-1:0]  m_pf [NS];

  int vectors = 0;
  int miscompares = 0;

  assign rd_src_addr = m_sa[rd_index];
  assign rd_src_size = m_ss[rd_index];
  assign rd_des_addr = m_da[rd_index];
  assign rd_des_size = m_ds[rd_index];
  assign rd_status   = m_st[rd_index];

  slot_sequencer #(
    .INDEX_WIDTH(IW), .SRC_ADDR_WIDTH(SAW), .SRC_SIZE_WIDTH(SSW),
    .DST_ADDR_WIDTH(DAW), .DST_SIZE_WIDTH(DSW), .STATUS_WIDTH(SW),
    .PROFILE_WIDTH(PW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .first_idx(first_idx),
    .last_idx(last_idx), .abort(abort), .busy(busy), .seq_done(seq_done),
    .seq_err(seq_err), .rd_index(rd_index), .rd_src_addr(rd_src_addr),
    .rd_src_size(rd_src_size), .rd_des_addr(rd_des_addr),
    .rd_des_size(rd_des_size), .rd_status(rd_status), .wr_index(wr_index),
    .wr_status(wr_status), .set_status(set_status), .wr_profile(wr_profile),
    .set_profile(set_profile), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src_addr(cmd_src_addr), .cmd_src_size(cmd_src_size),
    .cmd_des_addr(cmd_des_addr), .cmd_des_size(cmd_des_size),
    .dma_done(dma_done), .dma_err(dma_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input bit rnd_status);
    for (int i = 0; i < NS; i++) begin
      m_sa[i] = $urandom;
      m_ss[i] = SSW'($urandom);
      m_da[i] = $urandom;
      m_ds[i] = DSW'($urandom);
      m_st[i] = rnd_status ? SW'($urandom_range(0, 3)) : SW'(SLOT_READY);
      m_pf[i] = '0;
    end
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_busy"},        64'(busy),         64'(0));
    check({pfx, "_seq_done"},    64'(seq_done),     64'(0));
    check({pfx, "_seq_err"},     64'(seq_err),      64'(0));
    check({pfx, "_rd_index"},    64'(rd_index),     64'(0));
    check({pfx, "_wr_index"},    64'(wr_index),     64'(0));
    check({pfx, "_wr_status"},   64'(wr_status),    64'(0));
    check({pfx, "_set_status"},  64'(set_status),   64'(0));
    check({pfx, "_wr_profile"},  64'(wr_profile),   64'(0));
    check({pfx, "_set_profile"}, 64'(set_profile),  64'(0));
    check({pfx, "_cmd_valid"},   64'(cmd_valid),    64'(0));
    check({pfx, "_cmd_payload"}, 64'(cmd_src_addr ^ cmd_des_addr) | 64'(cmd_src_size) | 64'(cmd_des_size),
          64'(0));
  endtask

  // One whole sequence. err_slot: slot whose transfer fails (-1 none);
  // abort_cmd: ordinal of the command during whose WAIT abort is raised (-1 none);
  // lat_fix: fixed done latency (0 = random 1..6).
  task automatic run_seq(input int first, input int last, input int err_slot, input int abort_cmd,
                         input int lat_fix, input bit rdy_rand, input bit hold10, input bit spur);
    int             exp_q[$];
    logic [SW-1:0]  exp_st [NS];
    bit             exp_err, in_wait, held_v, fin, r;
    int             idx, cmd_n, wr_n, done_cnt, hold_cnt, wcnt, lat, wb_lat, cyc;
    logic [SAW-1:0] h_sa;
    logic [SSW-1:0] h_ss;
    logic [DAW-1:0] h_da;
    logic [DSW-1:0] h_ds;

    exp_err = 1'b0;
    for (int i = 0; i < NS; i++) exp_st[i] = m_st[i];
    idx = first;
    forever begin
      if (m_st[idx] == SW'(SLOT_READY)) begin
        exp_q.push_back(idx);
        if (idx == err_slot) begin
          exp_st[idx] = SW'(SLOT_ERROR);
          exp_err = 1'b1;
          break;
        end
        exp_st[idx] = SW'(SLOT_DONE);
        if (exp_q.size() - 1 == abort_cmd) break;
      end
      if (idx == last) break;
      idx = (idx + 1) % NS;
    end

    @(negedge clk);
    first_idx = IW'(first);
    last_idx  = IW'(last);
    start     = 1'b1;
    @(negedge clk);

    in_wait = 0; held_v = 0; fin = 0;
    cmd_n = 0; wr_n = 0; done_cnt = 0; hold_cnt = 0; wcnt = 0; lat = 1; wb_lat = 0; cyc = 0;
    while (!fin && cyc < 3000) begin
      start = 0; cmd_ready = 0; dma_done = 0; dma_err = 0; abort = 0;

      if (set_status) begin
        if (wr_n < exp_q.size()) begin
          check("wb_index", 64'(wr_index), 64'(exp_q[wr_n]));
          check("wb_status", 64'(wr_status),
                64'((exp_q[wr_n] == err_slot) ? SW'(SLOT_ERROR) : SW'(SLOT_DONE)));
          check("wb_set_profile", 64'(set_profile), 64'(1));
          check("wb_profile", 64'(wr_profile), 64'(wb_lat));
        end else begin
          check("wb_count", 64'(wr_n + 1), 64'(exp_q.size()));
        end
        m_st[wr_index] = wr_status;
        if (set_profile) m_pf[wr_index] = wr_profile;
        wr_n++;
      end

      if (in_wait) begin
        wcnt++;
        if (abort_cmd == cmd_n - 1 && wcnt == 1) abort = 1;
        if (wcnt == lat) begin
          if (cmd_n - 1 < exp_q.size() && exp_q[cmd_n - 1] == err_slot) begin
            dma_err  = 1;
            dma_done = 1;
          end else begin
            dma_done = 1;
          end
          in_wait = 0;
          wb_lat  = lat;
        end
      end else if (cmd_valid) begin
        if (held_v) begin
          check("stable_src_addr", 64'(cmd_src_addr), 64'(h_sa));
          check("stable_src_size", 64'(cmd_src_size), 64'(h_ss));
          check("stable_des_addr", 64'(cmd_des_addr), 64'(h_da));
          check("stable_des_size", 64'(cmd_des_size), 64'(h_ds));
        end else if (cmd_n < exp_q.size()) begin
          check("cmd_src_addr", 64'(cmd_src_addr), 64'(m_sa[exp_q[cmd_n]]));
          check("cmd_src_size", 64'(cmd_src_size), 64'(m_ss[exp_q[cmd_n]]));
          check("cmd_des_addr", 64'(cmd_des_addr), 64'(m_da[exp_q[cmd_n]]));
          check("cmd_des_size", 64'(cmd_des_size), 64'(m_ds[exp_q[cmd_n]]));
        end else begin
          check("cmd_count", 64'(cmd_n + 1), 64'(exp_q.size()));
        end
        h_sa = cmd_src_addr; h_ss = cmd_src_size; h_da = cmd_des_addr; h_ds = cmd_des_size;
        held_v = 1;
        if (hold10 && cmd_n == 0 && hold_cnt < 10) begin
          r = 0;
          hold_cnt++;
        end else if (rdy_rand) begin
          r = 1'($urandom_range(0, 1));
        end else begin
          r = 1;
        end
        if (r) begin
          cmd_ready = 1;
          held_v    = 0;
          cmd_n++;
          in_wait   = 1;
          wcnt      = 0;
          lat       = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 6));
          if (spur) dma_done = 1;
        end
      end

      if (busy && !seq_done && $urandom_range(0, 7) == 0) begin
        start     = 1;
        first_idx = IW'($urandom);
        last_idx  = IW'($urandom);
      end

      if (seq_done) begin
        done_cnt++;
        fin = 1;
      end
      @(negedge clk);
      cyc++;
    end
    start = 0; cmd_ready = 0; dma_done = 0; dma_err = 0; abort = 0;

    check("seq_done_seen", 64'(fin), 64'(1));
    check("done_pulses", 64'(done_cnt), 64'(1));
    check("done_deasserted", 64'(seq_done), 64'(0));
    check("idle_after_seq", 64'(busy), 64'(0));
    check("cmds_issued", 64'(cmd_n), 64'(exp_q.size()));
    check("writebacks", 64'(wr_n), 64'(exp_q.size()));
    check("seq_err", 64'(seq_err), 64'(exp_err));
    for (int i = 0; i < NS; i++)
      check($sformatf("slot%0d_status", i), 64'(m_st[i]), 64'(exp_st[i]));
  endtask

  initial begin
    int k, f, l, e, a;

    reset = 1; start = 0; abort = 0; cmd_ready = 0; dma_done = 0; dma_err = 0;
    first_idx = '0; last_idx = '0;
    fill(0);
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 0;
    @(negedge clk);
    check_outputs_zero("post_reset");

    // In-order range, fixed latency 3, ignored dma pulse in handshake cycle.
    fill(0);
    run_seq(2, 4, -1, -1, 3, 0, 0, 1);
    for (int i = 2; i <= 4; i++)
      check($sformatf("slot%0d_profile", i), 64'(m_pf[i]), 64'(3));

    // Wrapping range with an EMPTY slot skipped.
    fill(0);
    m_st[7] = SW'(SLOT_EMPTY);
    run_seq(6, 1, -1, -1, 0, 1, 0, 0);

    // cmd_ready held low for 10 cycles.
    fill(0);
    run_seq(0, 2, -1, -1, 2, 0, 1, 0);
    check("held_profile", 64'(m_pf[0]), 64'(2));

    // Transfer error mid-range.
    fill(0);
    run_seq(2, 5, 3, -1, 0, 1, 0, 0);

    // Abort during the first WAIT of a full-table range.
    fill(0);
    run_seq(0, 7, -1, 0, 0, 1, 0, 0);

    // Single-slot range.
    fill(0);
    run_seq(5, 5, -1, -1, 1, 0, 0, 0);

    // Randomized ranges, statuses, errors and aborts.
    for (int n = 0; n < 10; n++) begin
      fill(1);
      f = int'($urandom_range(0, 7));
      l = int'($urandom_range(0, 7));
      e = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
      run_seq(f, l, e, a, 0, 1, 0, 1'($urandom_range(0, 1)));
    end

    // Reset asserted while a command is in WAIT.
    fill(0);
    @(negedge clk);
    first_idx = 3'd0; last_idx = 3'd3; start = 1;
    @(negedge clk);
    start = 0; cmd_ready = 1; k = 0;
    while (!cmd_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("reached_issue", 64'(cmd_valid), 64'(1));
    @(negedge clk);
    cmd_ready = 0;
    check("in_wait_busy", 64'(busy), 64'(1));
    #2 reset = 1;
    #1 check_outputs_zero("async_reset");
    repeat (2) begin
      @(negedge clk);
      check("reset_no_strobe", 64'(set_status | set_profile), 64'(0));
    end
    reset = 0;
    repeat (3) begin
      @(negedge clk);
      check("post_reset_no_strobe", 64'(set_status | set_profile), 64'(0));
      check("post_reset_idle", 64'(busy), 64'(0));
    end
    check("slot0_untouched", 64'(m_st[0]), 64'(SW'(SLOT_READY)));
    run_seq(1, 3, -1, -1, 0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
